aba_err_monitor: RTL and testbench

- Streaming checker for the approximate 12-bit adder used in the 3x3 Gaussian FIR datapath.
- Accepts operand triples {cin, a, b} together with the approximate result {cout, s} that the adder produced, and recomputes the exact sum.
- Accumulates error statistics over a programmable window of samples, then raises done and holds the results.
- Sits beside each adder instance in the filter for accuracy characterisation on FPGA and in simulation.

---
 rtl/aba_pkg.sv | 13 +
 rtl/aba_err_calc.sv | 27 ++
 rtl/aba_err_monitor.sv | 138 +++++++++++++
 tb/tb_aba_err_monitor.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aba_pkg.sv
// Shared definitions for the approximate-adder error monitor and the adder it checks.
package aba_pkg;
  localparam int ADD_WIDTH = 12;
  localparam int LCA_WIDTH = 4;
  localparam int APX_BITS  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_t;
endpackage

// File: rtl/aba_err_calc.sv
// Combinational error of one approximate add: err = {cout_apx, s_apx} - (a + b + cin).
module aba_err_calc import aba_pkg::*; #(
  parameter int WIDTH = ADD_WIDTH
) (
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s_apx,
  input  logic             cout_apx,
  output logic [WIDTH+1:0] err,
  output logic [WIDTH:0]   abs_err
);

  logic [WIDTH:0]   exact;
  logic [WIDTH:0]   apx;
  logic [WIDTH+1:0] neg;

  always_comb begin
    exact   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    apx     = {cout_apx, s_apx};
    // One extra bit of headroom keeps the difference of two unsigned values signed-exact.
    err     = $signed({1'b0, apx}) - $signed({1'b0, exact});
    neg     = -err;
    abs_err = err[WIDTH+1] ? neg[WIDTH:0] : err[WIDTH:0];
  end

endmodule

// File: rtl/aba_err_monitor.sv
// Windowed error-statistics monitor for the approximate adder: a 2-stage pipeline
// (registered error, then statistics) under an IDLE/RUN/DRAIN/DONE controller.
module aba_err_monitor import aba_pkg::*; #(
  parameter int WIDTH = ADD_WIDTH,
  parameter int CNT_W = 16,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] window,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] s_apx,
  input  logic             cout_apx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   max_abs_err,
  output logic [ACC_W-1:0] err_sum
);

  localparam int ERR_W = WIDTH + 2;
  localparam int SUM_W = ((ACC_W > ERR_W) ? ACC_W : ERR_W) + 1;

  // Handshake: a sample transfers on a rising edge where in_valid && in_ready and
  // start is low; in_ready depends only on state, never on in_valid.
  mon_state_t state, state_next;

  logic [CNT_W-1:0]        win_q;
  logic [ERR_W-1:0]        err_c;
  logic [WIDTH:0]          abs_c;
  logic [ERR_W-1:0]        s1_err;
  logic [WIDTH:0]          s1_abs;
  logic                    s1_valid;
  logic                    s2_valid;
  logic                    accept;
  logic                    last;
  logic signed [SUM_W-1:0] sum_next;
  logic signed [SUM_W-1:0] sat_max;
  logic signed [SUM_W-1:0] sat_min;
  logic [ACC_W-1:0]        sum_sat;

  aba_err_calc #(.WIDTH(WIDTH)) u_calc (
    .cin      (cin),
    .a        (a),
    .b        (b),
    .s_apx    (s_apx),
    .cout_apx (cout_apx),
    .err      (err_c),
    .abs_err  (abs_c)
  );

  assign accept = in_valid && (state == RUN) && !start;
  assign last   = (sample_cnt + CNT_W'(1)) == win_q;

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: ;
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept && last) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (!s1_valid && !s2_valid) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (start) state_next = RUN;
  end

  // Accumulate in a wider signed domain, then clamp back to the ACC_W range.
  always_comb begin
    sat_max  = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    sat_min  = ~sat_max;
    sum_next = {{(SUM_W-ACC_W){err_sum[ACC_W-1]}}, err_sum}
             + {{(SUM_W-ERR_W){s1_err[ERR_W-1]}}, s1_err};
    if (sum_next > sat_max)      sum_sat = sat_max[ACC_W-1:0];
    else if (sum_next < sat_min) sum_sat = sat_min[ACC_W-1:0];
    else                         sum_sat = sum_next[ACC_W-1:0];
  end

  // The statistics registers form stage 2; s2_valid marks that slot as holding a
  // just-committed sample so DRAIN covers the commit cycle as well.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      win_q       <= '0;
      s1_err      <= '0;
      s1_abs      <= '0;
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      sample_cnt  <= '0;
      err_cnt     <= '0;
      max_abs_err <= '0;
      err_sum     <= '0;
    end else begin
      state <= state_next;
      if (start) begin
        win_q       <= (window == '0) ? CNT_W'(1) : window;
        s1_valid    <= 1'b0;
        s2_valid    <= 1'b0;
        sample_cnt  <= '0;
        err_cnt     <= '0;
        max_abs_err <= '0;
        err_sum     <= '0;
      end else begin
        s1_valid <= accept;
        s2_valid <= s1_valid;
        if (accept) begin
          sample_cnt <= sample_cnt + CNT_W'(1);
          s1_err     <= err_c;
          s1_abs     <= abs_c;
        end
        if (s1_valid) begin
          err_cnt <= err_cnt + CNT_W'(s1_err != '0);
          if (s1_abs > max_abs_err) max_abs_err <= s1_abs;
          err_sum <= sum_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_aba_err_monitor.sv
// Randomized self-checking bench for aba_err_monitor; two instances share stimulus
// so the saturating sum is checked at both a wide and a narrow accumulator width.
`timescale 1ns/1ps
module tb_aba_err_monitor;
  import aba_pkg::*;

  localparam int WIDTH = 12;
  localparam int CNT_W = 16;
  localparam int ACC_W = 24;
  localparam int ACC_S = 8;

  typedef struct packed {
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH:0]   apx;
  } smp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] window;
  logic             in_valid;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] s_apx;
  logic             cout_apx;
  logic             in_ready, busy, done;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [WIDTH:0]   max_abs_err;
  logic [ACC_W-1:0] err_sum;
  logic             in_ready8, busy8, done8;
  logic [CNT_W-1:0] sample_cnt8, err_cnt8;
  logic [WIDTH:0]   max_abs_err8;
  logic [ACC_S-1:0] err_sum8;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  smp_t             smp_q[$];
  logic [WIDTH+1:0] exp_q[$];

  aba_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst(rst), .start(start), .window(window), .in_valid(in_valid),
    .in_ready(in_ready), .cin(cin), .a(a), .b(b), .s_apx(s_apx), .cout_apx(cout_apx),
    .busy(busy), .done(done), .sample_cnt(sample_cnt), .err_cnt(err_cnt),
    .max_abs_err(max_abs_err), .err_sum(err_sum)
  );

  aba_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_S)) dut8 (
    .clk(clk), .rst(rst), .start(start), .window(window), .in_valid(in_valid),
    .in_ready(in_ready8), .cin(cin), .a(a), .b(b), .s_apx(s_apx), .cout_apx(cout_apx),
    .busy(busy8), .done(done8), .sample_cnt(sample_cnt8), .err_cnt(err_cnt8),
    .max_abs_err(max_abs_err8), .err_sum(err_sum8)
  );

  // Clock and done-pulse counter
  always #5 clk = ~clk;
  always @(negedge clk) if (done) done_cnt++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: arithmetic straight from the error definition
  function automatic longint ref_err(input smp_t s);
    return longint'(s.apx) - (longint'(s.a) + longint'(s.b) + longint'(s.cin));
  endfunction

  function automatic longint sat(input longint v, input int w);
    longint hi = (longint'(1) << (w - 1)) - 1;
    longint lo = -(longint'(1) << (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic smp_t mk(input logic c, input logic [WIDTH-1:0] x,
                              input logic [WIDTH-1:0] y, input logic [WIDTH:0] p);
    smp_t s;
    s.cin = c; s.a = x; s.b = y; s.apx = p;
    return s;
  endfunction

  function automatic smp_t gen_smp();
    smp_t s;
    logic [WIDTH:0] ex;
    s.cin = 1'($urandom_range(0, 1));
    s.a   = WIDTH'($urandom);
    s.b   = WIDTH'($urandom);
    ex    = {1'b0, s.a} + {1'b0, s.b} + {{WIDTH{1'b0}}, s.cin};
    case ($urandom_range(0, 3))
      0:       s.apx = ex;
      1, 2:    s.apx = {ex[WIDTH:APX_BITS], APX_BITS'($urandom)};
      default: s.apx = (WIDTH+1)'($urandom);
    endcase
    return s;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_smp(input smp_t s);
    cin = s.cin;
    a = s.a;
    b = s.b;
    {cout_apx, s_apx} = s.apx;
    in_valid = 1'b1;
  endtask

  task automatic drive_garbage();
    cin = 1'($urandom_range(0, 1));
    a = WIDTH'($urandom);
    b = WIDTH'($urandom);
    s_apx = WIDTH'($urandom);
    cout_apx = 1'($urandom_range(0, 1));
  endtask

  task automatic begin_window(input int win);
    start = 1'b1;
    window = CNT_W'(win);
    in_valid = 1'($urandom_range(0, 1));
    drive_garbage();
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    check_eq("start in_ready", in_ready, 1);
    check_eq("start sample_cnt clear", sample_cnt, 0);
    check_eq("start err_sum clear", longint'($signed(err_sum)), 0);
  endtask

  task automatic check_results(input string tag);
    longint cnt = 0, mx = 0, sum = 0, sum8 = 0, e;
    foreach (exp_q[i]) begin
      e = longint'($signed(exp_q[i]));
      if (e != 0) cnt++;
      if ((e < 0 ? -e : e) > mx) mx = (e < 0 ? -e : e);
      sum  = sat(sum + e, ACC_W);
      sum8 = sat(sum8 + e, ACC_S);
    end
    check_eq({tag, " done"}, done, 1);
    check_eq({tag, " done8"}, done8, 1);
    check_eq({tag, " sample_cnt"}, sample_cnt, exp_q.size());
    check_eq({tag, " err_cnt"}, err_cnt, cnt);
    check_eq({tag, " max_abs_err"}, max_abs_err, mx);
    check_eq({tag, " err_sum"}, longint'($signed(err_sum)), sum);
    check_eq({tag, " err_cnt8"}, err_cnt8, cnt);
    check_eq({tag, " max_abs_err8"}, max_abs_err8, mx);
    check_eq({tag, " err_sum8"}, longint'($signed(err_sum8)), sum8);
    check_eq({tag, " sample_cnt8"}, sample_cnt8, exp_q.size());
  endtask

  // Feeds smp_q[0..eff-1] with random gaps, then waits for done (bounded).
  task automatic finish_window(input int eff, input int gap_max, input string tag, input int d0);
    int lat;
    for (int i = 0; i < eff; i++) begin
      repeat ($urandom_range(0, gap_max)) begin
        drive_garbage();
        tick();
      end
      drive_smp(smp_q[i]);
      exp_q.push_back((WIDTH+2)'(ref_err(smp_q[i])));
      tick();
      in_valid = 1'b0;
      check_eq({tag, " sample_cnt step"}, sample_cnt, i + 1);
    end
    check_eq({tag, " in_ready after last"}, in_ready, 0);
    check_eq({tag, " in_ready8 after last"}, in_ready8, 0);
    check_eq({tag, " busy after last"}, busy, 1);
    in_valid = 1'b1;
    drive_garbage();
    lat = 1;
    while (!done && lat < 16) begin
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check_eq({tag, " done latency"}, lat, 4);
    check_results(tag);
    tick();
    check_eq({tag, " done count"}, done_cnt - d0, 1);
    check_eq({tag, " done low after"}, done, 0);
    check_eq({tag, " busy low after"}, busy, 0);
    check_eq({tag, " busy8 low after"}, busy8, 0);
    check_eq({tag, " stats hold"}, sample_cnt, exp_q.size());
  endtask

  task automatic run_window(input int win, input int gap_max, input string tag);
    int d0 = done_cnt;
    int eff = (win == 0) ? 1 : win;
    begin_window(win);
    finish_window(eff, gap_max, tag, d0);
  endtask

  initial begin
    int d0, held;
    rst = 1'b1; start = 1'b0; window = '0; in_valid = 1'b0;
    cin = 1'b0; a = '0; b = '0; s_apx = '0; cout_apx = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset in_ready", in_ready, 0);
    check_eq("reset busy", busy, 0);
    check_eq("reset done", done, 0);
    check_eq("reset sample_cnt", sample_cnt, 0);
    check_eq("reset err_cnt", err_cnt, 0);
    check_eq("reset max_abs_err", max_abs_err, 0);
    check_eq("reset err_sum", err_sum, 0);
    rst = 1'b0;
    tick();

    smp_q = '{mk(1'b0, 12'h0F0, 12'h010, 13'h0100)};
    run_window(1, 0, "exact");
    smp_q = '{mk(1'b0, 12'h123, 12'h456, 13'h0570)};
    run_window(1, 2, "negative");
    smp_q = '{mk(1'b0, 12'h123, 12'h456, 13'h0570), mk(1'b0, 12'h00F, 12'h001, 13'h001F),
              mk(1'b0, 12'h0F0, 12'h010, 13'h0100)};
    run_window(3, 0, "multi");

    // in_valid while IDLE must be ignored
    held = sample_cnt;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    check_eq("idle in_ready", in_ready, 0);
    check_eq("idle sample_cnt hold", sample_cnt, held);

    smp_q = '{gen_smp()};
    run_window(0, 1, "window0");

    // Abort: restart after two samples, coincident with a handshake that must drop
    d0 = done_cnt;
    begin_window(4);
    drive_smp(mk(1'b0, 12'h123, 12'h456, 13'h0570));
    tick();
    drive_smp(mk(1'b0, 12'h00F, 12'h001, 13'h001F));
    tick();
    drive_smp(mk(1'b0, 12'hFFF, 12'hFFF, 13'h0000));
    start = 1'b1;
    window = CNT_W'(1);
    tick();
    start = 1'b0;
    in_valid = 1'b0;
    check_eq("abort sample_cnt", sample_cnt, 0);
    check_eq("abort in_ready", in_ready, 1);
    tick();
    check_eq("abort flushed err_cnt", err_cnt, 0);
    check_eq("abort flushed max", max_abs_err, 0);
    exp_q.delete();
    smp_q = '{mk(1'b1, 12'h0F0, 12'h00F, 13'h00F0)};
    finish_window(1, 0, "abort", d0);

    smp_q.delete();
    repeat (20) smp_q.push_back(mk(1'b0, 12'h00F, 12'h001, 13'h001F));
    run_window(20, 1, "sat_pos");
    smp_q.delete();
    repeat (30) smp_q.push_back(mk(1'b0, 12'hFFF, 12'hFFF, 13'h0000));
    run_window(30, 0, "sat_neg");
    smp_q.delete();
    repeat (1100) smp_q.push_back(mk(1'b0, 12'h000, 12'h000, 13'h1FFF));
    run_window(1100, 0, "sat_wide");

    for (int r = 0; r < 6; r++) begin
      int win = $urandom_range(1, 40);
      smp_q.delete();
      repeat (win) smp_q.push_back(gen_smp());
      run_window(win, 3, "random");
    end

    // Reset with the pipeline full
    begin_window(8);
    drive_smp(mk(1'b0, 12'h123, 12'h456, 13'h0570));
    tick();
    drive_smp(mk(1'b0, 12'h00F, 12'h001, 13'h001F));
    tick();
    drive_smp(mk(1'b0, 12'hFFF, 12'hFFF, 13'h0000));
    tick();
    #2 rst = 1'b1;
    #1;
    check_eq("midrst in_ready", in_ready, 0);
    check_eq("midrst busy", busy, 0);
    check_eq("midrst sample_cnt", sample_cnt, 0);
    check_eq("midrst err_cnt", err_cnt, 0);
    check_eq("midrst max_abs_err", max_abs_err, 0);
    check_eq("midrst err_sum", err_sum, 0);
    check_eq("midrst err_sum8", err_sum8, 0);
    in_valid = 1'b0;
    #1 rst = 1'b0;
    tick();
    check_eq("postrst in_ready", in_ready, 0);
    smp_q = '{mk(1'b0, 12'h0F0, 12'h010, 13'h0100)};
    run_window(1, 0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
